// File: rtl/icache_defs.sv
// icache_defs: shared definitions for the instruction-cache response block.
// Holds the FSM state encodings, the kseg1 segment code and the address
// field constants that do not depend on the number of sets.
package icache_defs;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOOKUP    = 3'd1;
    localparam logic [STATE_W-1:0] ST_MISS_REQ  = 3'd2;
    localparam logic [STATE_W-1:0] ST_MISS_FILL = 3'd3;
    localparam logic [STATE_W-1:0] ST_UNC_REQ   = 3'd4;
    localparam logic [STATE_W-1:0] ST_UNC_WAIT  = 3'd5;
    localparam logic [STATE_W-1:0] ST_RESP      = 3'd6;

    // Top three virtual-address bits selecting the uncached kseg1 window.
    localparam logic [2:0] KSEG1 = 3'b101;

    // Byte-in-word bits, and the lowest index bit (4 words of 4 bytes per line).
    localparam int BYTE_OFF_W = 2;
    localparam int LINE_LSB   = 4;

    function automatic logic is_uncached(input logic [2:0] seg);
        return seg == KSEG1;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: line data storage, one 32-bit word per entry, indexed by
// {set, word}. Synchronous write, combinational read; no reset because
// entries are only ever read behind a valid bit.
module icache_data_ram #(
    parameter  int SETS = 64,
    localparam int AW   = $clog2(SETS) + 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [SETS*4];

    // Refill beats land here one word per cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_resp.sv
// icache_resp: direct-mapped instruction cache front end. Takes a one-cycle
// fetch pulse, looks the word up, refills a whole line on a miss, fetches a
// single word for kseg1 addresses, and answers with a one-cycle ready pulse.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cache_call_begin
// LOOKUP    | tag/valid compare; a hit answers straight from here
// MISS_REQ  | line read request held until mem_rd_ack
// MISS_FILL | collecting 4 beats into the data RAM
// UNC_REQ   | single-word uncached read request held until mem_rd_ack
// UNC_WAIT  | waiting for the uncached data beat
// RESP      | ready pulse visible for a miss or uncached fetch
module icache_resp #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_call_begin,
    input  logic [31:0] IF_pc_out,
    output logic        cache_return_ready,
    output logic [31:0] cache_return_instruction,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    output logic [1:0]  mem_rd_len,
    input  logic        mem_rd_ack,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_last
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    import icache_defs::*;

    localparam int IDX_W   = $clog2(SETS);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int WA_W    = 32 - BYTE_OFF_W;
    localparam int TAG_LSB = LINE_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    logic [STATE_W-1:0] state_q, state_d;
    logic [31:2]        va_q, va_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [31:0]        word_q, word_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         len_q, len_d;
    logic               ready_q, ready_d;
    logic [31:0]        instr_q, instr_d;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q [SETS];

    // Word address of the physical fetch address; the top three bits are
    // always zero because the segment bits are stripped.
    logic [WA_W-1:0]  pa_w;
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             uncached;
    logic             hit;
    logic             fill_beat;
    logic             fill_done;
    logic             unc_beat;
    logic [31:0]      ram_rdata;

    // Fetches are word aligned; the byte offset of the PC is not needed.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^IF_pc_out[1:0];

    assign pa_w     = {3'b000, va_q[28:2]};
    assign off      = pa_w[OFF_W-1:0];
    assign idx      = pa_w[OFF_W +: IDX_W];
    assign tag      = pa_w[WA_W-1 -: TAG_W];
    assign uncached = is_uncached(va_q[31:29]);
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    // A beat that arrives together with the ack is already part of the burst.
    assign fill_beat = mem_rd_valid &&
                       ((state_q == ST_MISS_FILL) || ((state_q == ST_MISS_REQ) && mem_rd_ack));
    assign fill_done = fill_beat && mem_rd_last;
    assign unc_beat  = mem_rd_valid &&
                       ((state_q == ST_UNC_WAIT) || ((state_q == ST_UNC_REQ) && mem_rd_ack));

    icache_data_ram #(.SETS(SETS)) u_data_ram (
        .clk   (clk),
        .we    (fill_beat),
        .waddr ({idx, beat_q}),
        .wdata (mem_rd_data),
        .raddr ({idx, off}),
        .rdata (ram_rdata)
    );

    // Next-state and output decode; beat handling follows the case so a beat
    // on the ack cycle overrides the plain request-to-wait transition.
    always_comb begin
        state_d = state_q;
        va_d    = va_q;
        beat_d  = beat_q;
        word_d  = word_q;
        req_d   = req_q;
        addr_d  = addr_q;
        len_d   = len_q;
        ready_d = 1'b0;
        instr_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (cache_call_begin) begin
                    va_d    = IF_pc_out[31:2];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (uncached) begin
                    req_d   = 1'b1;
                    addr_d  = {pa_w, 2'b00};
                    len_d   = 2'd0;
                    state_d = ST_UNC_REQ;
                end else if (hit) begin
                    ready_d = 1'b1;
                    instr_d = ram_rdata;
                    state_d = ST_IDLE;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = {pa_w[WA_W-1:OFF_W], {(OFF_W + BYTE_OFF_W){1'b0}}};
                    len_d   = 2'(LINE_WORDS - 1);
                    beat_d  = '0;
                    state_d = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                if (mem_rd_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_MISS_FILL;
                end
            end
            ST_MISS_FILL: begin
            end
            ST_UNC_REQ: begin
                if (mem_rd_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_UNC_WAIT;
                end
            end
            ST_UNC_WAIT: begin
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fill_beat) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == off) begin
                word_d = mem_rd_data;
            end
            if (mem_rd_last) begin
                beat_d  = '0;
                ready_d = 1'b1;
                instr_d = (beat_q == off) ? mem_rd_data : word_q;
                state_d = ST_RESP;
            end
        end

        if (unc_beat) begin
            ready_d = 1'b1;
            instr_d = mem_rd_data;
            state_d = ST_RESP;
        end
    end

    // Control, request and response registers plus the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            va_q    <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            ready_q <= 1'b0;
            instr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag is written together with the valid bit; no reset needed.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[idx] <= tag;
        end
    end

    assign cache_return_ready       = ready_q;
    assign cache_return_instruction = instr_q;
    assign mem_rd_req               = req_q;
    assign mem_rd_addr              = addr_q;
    assign mem_rd_len               = len_q;

`ifdef ICACHE_STATS_EN
    logic        lookup_hit;
    logic        lookup_miss;
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    assign lookup_hit  = (state_q == ST_LOOKUP) && !uncached && hit;
    assign lookup_miss = (state_q == ST_LOOKUP) && !uncached && !hit;

    // Free-running cached hit/miss counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (lookup_hit) begin
                hits_q <= hits_q + 32'd1;
            end
            if (lookup_miss) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed vector table, mid-refill reset sequence and a
// randomized fetch stream checked against a set-indexed line model.
module tb_icache_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_call_begin;
    logic [31:0] IF_pc_out;
    logic        cache_return_ready;
    logic [31:0] cache_return_instruction;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [1:0]  mem_rd_len;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_rd_last;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    always #5 clk = ~clk;

    icache_resp #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache_call_begin         (cache_call_begin),
        .IF_pc_out                (IF_pc_out),
        .cache_return_ready       (cache_return_ready),
        .cache_return_instruction (cache_return_instruction),
        .mem_rd_req               (mem_rd_req),
        .mem_rd_addr              (mem_rd_addr),
        .mem_rd_len               (mem_rd_len),
        .mem_rd_ack               (mem_rd_ack),
        .mem_rd_valid             (mem_rd_valid),
        .mem_rd_data              (mem_rd_data),
        .mem_rd_last              (mem_rd_last)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits                (stat_hits),
        .stat_misses              (stat_misses)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Memory-side knobs and observations.
    int          ack_dly       = 0;
    bit          ack_with_data = 0;
    int          beat_limit    = 4;
    int          gap_max       = 0;
    int          req_count     = 0;
    int          beats_sent    = 0;
    int          stable_bad    = 0;
    logic [31:0] last_req_addr = '0;
    logic [1:0]  last_req_len  = '0;

    logic [31:0] mem_ovr [logic [31:0]];

    // Reference model: which line each set holds, plus expected counters.
    logic [31:0] model_line [int];
    int          m_hits   = 0;
    int          m_misses = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_expect(input logic [31:0] va, output bit hit,
                                output logic [31:0] raddr, output logic [1:0] len,
                                output logic [31:0] word);
        logic [31:0] pa;
        logic [31:0] line;
        int          set;
        pa   = {3'b000, va[28:0]};
        line = pa & 32'hFFFF_FFF0;
        set  = int'((pa >> 4) % 64);
        word = memval(pa & 32'hFFFF_FFFC);
        if (va[31:29] == 3'b101) begin
            hit   = 1'b0;
            raddr = pa & 32'hFFFF_FFFC;
            len   = 2'd0;
        end else if (model_line.exists(set) && model_line[set] == line) begin
            hit   = 1'b1;
            raddr = '0;
            len   = 2'd0;
            m_hits++;
        end else begin
            hit   = 1'b0;
            raddr = line;
            len   = 2'd3;
            model_line[set] = line;
            m_misses++;
        end
    endtask

    // Memory responder: optional ack delay with junk beats, optional data on
    // the ack cycle, random gaps, and a beat limit used to strand a refill.
    initial begin
        logic [31:0] a;
        logic [1:0]  l;
        int          nb;
        int          bi;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_last  = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            mem_rd_ack   = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_last  = 1'b0;
            if (!reset && mem_rd_req) begin
                a = mem_rd_addr;
                l = mem_rd_len;
                last_req_addr = a;
                last_req_len  = l;
                req_count++;
                beats_sent = 0;
                nb = int'(l) + 1;
                for (int i = 0; i < ack_dly; i++) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_last  = 1'b1;
                    mem_rd_data  = $urandom;
                    @(negedge clk);
                    mem_rd_valid = 1'b0;
                    mem_rd_last  = 1'b0;
                    if (mem_rd_req !== 1'b1 || mem_rd_addr !== a || mem_rd_len !== l ||
                        cache_return_ready !== 1'b0)
                        stable_bad++;
                end
                mem_rd_ack = 1'b1;
                bi = 0;
                if (ack_with_data && beat_limit > 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = memval(a);
                    mem_rd_last  = (nb == 1);
                    beats_sent++;
                    bi = 1;
                end
                @(negedge clk);
                mem_rd_ack   = 1'b0;
                mem_rd_valid = 1'b0;
                mem_rd_last  = 1'b0;
                while (bi < nb) begin
                    if (bi >= beat_limit) begin
                        for (int k = 0; k < 200 && !reset; k++) @(negedge clk);
                        break;
                    end
                    repeat ($urandom_range(0, gap_max)) @(negedge clk);
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = memval(a + 32'(4 * bi));
                    mem_rd_last  = (bi == nb - 1);
                    beats_sent++;
                    bi++;
                    @(negedge clk);
                    mem_rd_valid = 1'b0;
                    mem_rd_last  = 1'b0;
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] va, output int lat, output logic [31:0] instr,
                            output int nreq, output int beats, output int zb);
        int rc0;
        rc0 = req_count;
        zb  = 0;
        @(negedge clk);
        cache_call_begin = 1'b1;
        IF_pc_out        = va;
        @(negedge clk);
        cache_call_begin = 1'b0;
        IF_pc_out        = $urandom;
        lat = 1;
        while (cache_return_ready !== 1'b1 && lat < 300) begin
            if (cache_return_instruction !== 32'h0) zb++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 300) lat = -1;
        instr = cache_return_instruction;
        beats = beats_sent;
        @(negedge clk);
        if (cache_return_ready !== 1'b0) zb++;
        if (cache_return_instruction !== 32'h0) zb++;
        nreq = req_count - rc0;
    endtask

    task automatic check_fetch(input string nm, input logic [31:0] va, input bit exp_hit,
                               input logic [31:0] exp_addr, input logic [1:0] exp_len,
                               input logic [31:0] exp_instr);
        int          lat;
        int          nreq;
        int          beats;
        int          zb;
        logic [31:0] instr;
        do_fetch(va, lat, instr, nreq, beats, zb);
        chk({nm, " instr"}, instr, exp_instr);
        chk({nm, " nreq"}, nreq, exp_hit ? 0 : 1);
        chk({nm, " zero_when_idle"}, zb, 0);
        if (exp_hit) begin
            chk({nm, " hit_latency"}, lat, 2);
        end else begin
            chk({nm, " req_addr"}, last_req_addr, exp_addr);
            chk({nm, " req_len"}, {30'd0, last_req_len}, {30'd0, exp_len});
            chk({nm, " beats_before_ready"}, beats, int'(exp_len) + 1);
        end
    endtask

    typedef struct {
        logic [31:0] va;
        bit          hit;
        logic [31:0] raddr;
        logic [1:0]  len;
        logic [31:0] instr;
        int          ack_dly;
        bit          awd;
    } vec_t;

    vec_t tv [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [31:0] ea;
        logic [1:0]  el;
        logic [31:0] ew;
        logic [31:0] va;
        int          rc0;
        int          k;

        reset            = 1'b1;
        cache_call_begin = 1'b0;
        IF_pc_out        = '0;

        mem_ovr[32'h1FC00000] = 32'h3C08BFC0;
        mem_ovr[32'h00000010] = 32'h11;
        mem_ovr[32'h00000014] = 32'h22;
        mem_ovr[32'h00000018] = 32'h33;
        mem_ovr[32'h0000001C] = 32'h44;
        for (int i = 0; i < 4; i++)
            mem_ovr[32'h410 + 32'(4 * i)] = 32'hAA000410 + 32'(4 * i);

        tv[0] = '{32'hBFC00000, 1'b0, 32'h1FC00000, 2'd0, 32'h3C08BFC0, 1, 1'b0};
        tv[1] = '{32'h80000010, 1'b0, 32'h00000010, 2'd3, 32'h00000011, 0, 1'b0};
        tv[2] = '{32'h8000001C, 1'b1, 32'h00000000, 2'd0, 32'h00000044, 0, 1'b0};
        tv[3] = '{32'h80000410, 1'b0, 32'h00000410, 2'd3, 32'hAA000410, 5, 1'b0};
        tv[4] = '{32'h80000010, 1'b0, 32'h00000010, 2'd3, 32'h00000011, 0, 1'b1};
        tv[5] = '{32'h80000014, 1'b1, 32'h00000000, 2'd0, 32'h00000022, 0, 1'b0};
        tv[6] = '{32'hA0000418, 1'b0, 32'h00000418, 2'd0, 32'hAA000418, 2, 1'b1};
        tv[7] = '{32'h80000418, 1'b0, 32'h00000410, 2'd3, 32'hAA000418, 1, 1'b1};
        tv[8] = '{32'h00000414, 1'b1, 32'h00000000, 2'd0, 32'hAA000414, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst ready", {31'd0, cache_return_ready}, 32'd0);
        chk("rst instr", cache_return_instruction, 32'd0);
        chk("rst req", {31'd0, mem_rd_req}, 32'd0);
        chk("rst addr", mem_rd_addr, 32'd0);
        chk("rst len", {30'd0, mem_rd_len}, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst stat_hits", stat_hits, 32'd0);
        chk("rst stat_misses", stat_misses, 32'd0);
`endif
        reset = 1'b0;

        gap_max = 1;
        for (int i = 0; i < 9; i++) begin
            ack_dly       = tv[i].ack_dly;
            ack_with_data = tv[i].awd;
            model_expect(tv[i].va, h, ea, el, ew);
            check_fetch($sformatf("vec%0d", i), tv[i].va, tv[i].hit, tv[i].raddr,
                        tv[i].len, tv[i].instr);
`ifdef ICACHE_STATS_EN
            if (i == 2) begin
                chk("stats hits after hit", stat_hits, 32'd1);
                chk("stats misses after hit", stat_misses, 32'd1);
            end
`endif
        end
        chk("req stable while ack low", stable_bad, 0);

        // Reset after the second beat of a refill, then refetch the line.
        ack_dly       = 0;
        ack_with_data = 0;
        gap_max       = 0;
        beat_limit    = 2;
        rc0           = req_count;
        @(negedge clk);
        cache_call_begin = 1'b1;
        IF_pc_out        = 32'h80000020;
        @(negedge clk);
        cache_call_begin = 1'b0;
        for (k = 0; k < 100 && !(req_count > rc0 && beats_sent >= 2); k++) @(negedge clk);
        @(negedge clk);
        chk("midfill beats", beats_sent, 2);
        chk("midfill no ready", {31'd0, cache_return_ready}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midfill rst req", {31'd0, mem_rd_req}, 32'd0);
        chk("midfill rst ready", {31'd0, cache_return_ready}, 32'd0);
        chk("midfill rst addr", mem_rd_addr, 32'd0);
        reset = 1'b0;
        beat_limit = 4;
        model_line.delete();
        m_hits   = 0;
        m_misses = 0;
        model_expect(32'h80000020, h, ea, el, ew);
        check_fetch("refill after reset", 32'h80000020, h, ea, el, ew);
        model_expect(32'h80000024, h, ea, el, ew);
        check_fetch("hit after refill", 32'h80000024, h, ea, el, ew);

        // Random fetch stream over a small address window to mix hits,
        // conflicts, aliases across kuseg/kseg0, and uncached reads.
        gap_max = 2;
        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 7);
            va = 32'($urandom_range(0, 1023)) << 2;
            if (k == 0)      va = va | 32'hA0000000;
            else if (k != 1) va = va | 32'h80000000;
            ack_dly       = $urandom_range(0, 3);
            ack_with_data = 1'($urandom_range(0, 1));
            model_expect(va, h, ea, el, ew);
            check_fetch($sformatf("rnd%0d", n), va, h, ea, el, ew);
        end
        chk("req stable (random)", stable_bad, 0);
`ifdef ICACHE_STATS_EN
        chk("final stat_hits", stat_hits, 32'(m_hits));
        chk("final stat_misses", stat_misses, 32'(m_misses));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
